// File: rtl/pwm_drive_bank.sv
// pwm_drive_bank: one shared period counter feeding NCH PWM channels, each with a
// slew-limited duty ramp, a hard duty cap and a brake override.
module pwm_drive_bank #(
  parameter int NCH = 5,
  parameter int PERIOD = 625000,
  parameter int CW = 20,
  parameter int MAX_PCT = 80,
  parameter int RAMP_STEP = 5,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               brake,
  input  logic               wr_en,
  input  logic [CHW-1:0]     wr_ch,
  input  logic [6:0]         wr_duty,
  output logic [NCH-1:0]     pwm_out,
  output logic               period_tick,
  output logic [7*NCH-1:0]   cur_duty,
  output logic [NCH-1:0]     at_target
);
  localparam int STEP_CNT = PERIOD / 100;
  logic [CW-1:0] cnt;
  logic b;
  assign b = en && cnt == CW'(PERIOD - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt <= (b || !en) ? '0 : cnt + CW'(1);
      period_tick <= b;
    end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [6:0] tgt, cur, nxt;
    logic [7:0] up, down;
    logic [CW-1:0] thr;
    logic pwm;
    // down is only meaningful when cur > tgt, so the subtraction never wraps there
    assign up = {1'b0, cur} + 8'(RAMP_STEP);
    assign down = {1'b0, cur - tgt};
    assign nxt = cur < tgt ? (up < {1'b0, tgt} ? up[6:0] : tgt)
               : cur > tgt ? (down > 8'(RAMP_STEP) ? cur - 7'(RAMP_STEP) : tgt) : cur;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        tgt <= '0;
        cur <= '0;
        thr <= '0;
        pwm <= 1'b0;
      end else begin
        if (wr_en && wr_ch == CHW'(c)) tgt <= wr_duty > 7'(MAX_PCT) ? 7'(MAX_PCT) : wr_duty;
        if (brake) begin
          cur <= '0;
          thr <= '0;
        end else if (b) begin
          cur <= nxt;
          thr <= CW'(nxt) * CW'(STEP_CNT);
        end
        pwm <= en && !brake && cnt < thr;
      end
    assign pwm_out[c] = pwm;
    assign cur_duty[7*c +: 7] = cur;
    assign at_target[c] = cur == tgt;
  end
endmodule

// File: doc/pwm_drive_bank.md
# pwm_drive_bank

Parametrised multi-channel PWM generator for the drive H-bridge enables and any other duty-driven actuator. It replaces the set of fixed-percentage, free-running PWM counters with one shared period counter and NCH independently programmable channels. Each channel has a slew-limited duty ramp, a hard duty cap, and a brake override. The drive state machine writes target duties by channel and routes `pwm_out` bits to `hbEnA`/`hbEnB`.

## Interface
- `NCH`, 5: number of PWM channels (1..16).
- `PERIOD`, 625000: clocks per PWM period (50 MHz / 80 Hz). Must be a multiple of 100.
- `CW`, 20: period counter width. Must satisfy 2^CW > PERIOD.
- `MAX_PCT`, 80: duty cap in percent (≤100). Set by the H-bridge 2.5 A stall limit.
- `RAMP_STEP`, 5: maximum change in current duty per period, in percent (≥1).
- `CHW`, derived: channel-index width, clog2(NCH), minimum 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable.
- `brake` in 1: forces all outputs off and zeroes current duties.
- `wr_en` in 1: target-duty write strobe.
- `wr_ch` in CHW: channel index for the write.
- `wr_duty` in 7: target duty, percent 0..127.
- `pwm_out` out NCH: registered PWM outputs.
- `period_tick` out 1: one-cycle pulse at the start of each period.
- `cur_duty` out 7*NCH: packed current duties; channel i occupies [7i+6:7i].
- `at_target` out NCH: `cur_duty[i] == target[i]`.

## Operation
- Derived constant: `STEP_CNT = PERIOD/100`.
- Per-channel state: `target[i]` (7 b), `cur[i]` (7 b), `thr[i]` (CW b). `thr[i]` always equals `cur[i]*STEP_CNT`.
- **Counter `cnt`:**
  - When `en=1`, `cnt` increments each cycle.
  - Boundary event B is `en && cnt==PERIOD-1`. On B, `cnt` returns to 0.
  - When `en=0`, `cnt` is held at 0.
- **Writes:**
  - On `wr_en` with `wr_ch<NCH`, `target[wr_ch] <= min(wr_duty, MAX_PCT)`.
  - Writes with `wr_ch>=NCH` are ignored with no side effects.
- **Ramp, on B, for every channel:**
  - If `cur < target`: `cur <= min(cur+RAMP_STEP, target)`.
  - If `cur > target`: `cur <= max(cur-RAMP_STEP, target)`. Compute with no underflow.
  - Otherwise `cur` is unchanged.
  - `thr` is loaded in the same edge from the new `cur`.
- **Output:**
  - `pwm_out[i] <= en && !brake && (cnt < thr[i])`.
  - Duty 0 gives a constant-low output. Duty D gives exactly D*STEP_CNT high cycles per period.
- **Brake:**
  - While `brake=1`, every cycle forces `cur[i] <= 0`, `thr[i] <= 0` and `pwm_out <= 0`. No ramp occurs.
  - `target` is retained. `cnt` keeps running if `en=1`.
  - After release, channels ramp up from 0 at the next B.
- **Disable (`en=0`):**
  - `pwm_out <= 0`, `period_tick <= 0`.
  - `cur`, `thr` and `target` are held. Writes are still accepted.
- `period_tick <= B`.

## Timing
- **Reset:** all of `cnt`, `target`, `cur`, `thr`, `pwm_out` and `period_tick` are 0. `at_target` is all 1s. All take effect immediately on `rst`, independent of `clk`.
- **Output latency:** `pwm_out` and `period_tick` are one cycle behind `cnt`. `period_tick` is high in the cycle in which `cnt==0` following a wrap.
- **Duty update latency:** a written target first affects `cur` at the next B. The first changed high pulse begins 1 cycle after that B.
- **Write coinciding with B (same edge):** the ramp uses the old target, and the new target is applied at the following B.
- **Brake and B in the same cycle:** brake wins, giving `cur=0`.
- **`at_target`:** combinational from registers. It updates in the same cycle as `cur` or `target`.
- **Reset released mid-period:** counting restarts from 0 on the first cycle with `en=1`.

## Test plan
Bench parameters: `PERIOD=200` (`STEP_CNT=2`), `NCH=5`, `MAX_PCT=80`, `RAMP_STEP=10`.

1. **Ramp up:** reset, `en=1`, write ch0=30 → ch0 high 20, then 40, then 60 cycles in the next three periods. `at_target[0]` rises after the third B. Other channels stay low.
2. **Clamp and ramp down:** write ch1=95 → `target=80`; after 8 periods ch1 is high 160 of 200 cycles. Then write ch1=55 → `cur` goes 70, 60, 55 on successive B.
3. **Brake:** assert `brake` mid-high pulse with ch1 at 80 → `pwm_out` goes 0 on the next cycle and `cur_duty` reads 0. Release → ch1 is 10 at the next B and ramps back to 80.
4. **Boundary collisions:** write ch2=40 on the B cycle → `cur[2]` is unchanged at that B and becomes 10 at the next B. A write with `wr_ch=5` or `7` leaves all targets and outputs unchanged.
5. **Enable and reset:** `en=0` mid-period → `pwm_out` is 0 and `cnt` is 0, while `cur` is held. Re-enable → `period_tick` fires 200 cycles later. Assert `rst` asynchronously mid-pulse → all outputs are 0 before the next clk edge, and `at_target` is all 1s.
6. **Duty extremes:** write ch3=0 → `pwm_out[3]` never high. Write ch4=80 with `RAMP_STEP` reached exactly → no overshoot, and `cur` saturates at exactly 80.
